// File: rtl/hazard_flush_control.sv
// Hazard and flush control for a five-stage pipeline.
// Detects load-use hazards between the instruction in ID and a load in EX,
// and handles control redirects (taken branch or jr) that are resolved in EX.
// Stalls hold PC and IF/ID and inject a bubble. Redirects squash the IF/ID
// register and the ID control signals for FLUSH_CYCLES cycles.
// Two saturating event counters record stalls and redirects.
module hazard_flush_control #(
    parameter int FLUSH_CYCLES = 1,   // legal range 1..3
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_PCSrc,
    input  logic             EX_JRControl,
    output logic             flush,
    output logic             IFID_flush,
    output logic             PC_write,
    output logic             IFID_write,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Remaining flush cycles after the redirect cycle itself.
    localparam logic [1:0] REMAIN_INIT = 2'(FLUSH_CYCLES - 1);

    // Counter slot indices.
    localparam int IDX_STALL    = 0;
    localparam int IDX_REDIRECT = 1;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] remain_reg;
    logic [1:0] remain_next;

    logic       redirect;
    logic       load_use;
    logic       rs_match;
    logic       rt_match;
    logic [1:0] cnt_inc;

    logic [1:0][CNT_W-1:0] count_all;

    // Hazard qualifiers. $zero is never a real dependence, so it is excluded.
    always_comb begin
        rs_match = (EX_rt == ID_rs);
        rt_match = ID_UsesRt && (EX_rt == ID_rt);
        redirect = EX_PCSrc || EX_JRControl;
        load_use = EX_MemRead && (EX_rt != 5'd0) && (rs_match || rt_match);
    end

    // State and remaining-flush register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            remain_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
        end
    end

    // Next-state, pipeline control outputs and counter increment requests.
    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        flush       = 1'b0;
        IFID_flush  = 1'b0;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        cnt_inc     = 2'b00;

        unique case (state_reg)
            ST_RUN, ST_STALL: begin
                if (redirect) begin
                    // Redirect wins over any load-use hazard in the same cycle.
                    flush                 = 1'b1;
                    IFID_flush            = 1'b1;
                    cnt_inc[IDX_REDIRECT] = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next  = ST_FLUSH;
                        remain_next = REMAIN_INIT;
                    end else begin
                        state_next  = ST_RUN;
                        remain_next = 2'd0;
                    end
                end else if (load_use && (state_reg == ST_RUN)) begin
                    // The stall cycle itself never re-stalls: the load has
                    // moved on and EX holds the injected bubble.
                    flush              = 1'b1;
                    PC_write           = 1'b0;
                    IFID_write         = 1'b0;
                    cnt_inc[IDX_STALL] = 1'b1;
                    state_next         = ST_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end

            ST_FLUSH: begin
                // EX holds squashed bubbles, so hazard inputs are meaningless here.
                flush      = 1'b1;
                IFID_flush = 1'b1;
                if (remain_reg <= 2'd1) begin
                    state_next  = ST_RUN;
                    remain_next = 2'd0;
                end else begin
                    remain_next = remain_reg - 2'd1;
                end
            end

            default: begin
                state_next  = ST_RUN;
                remain_next = 2'd0;
            end
        endcase

        // Reset holds the front end frozen and squashed.
        if (reset) begin
            flush      = 1'b1;
            IFID_flush = 1'b1;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            cnt_inc    = 2'b00;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_counter
            logic [CNT_W-1:0] count_reg;

            // Saturating event counter; holds at all-ones instead of wrapping.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            assign count_all[gi] = count_reg;
        end
    endgenerate

    assign stall_count    = count_all[IDX_STALL];
    assign redirect_count = count_all[IDX_REDIRECT];

endmodule
